// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one slow-memory line port between the I-cache
// and D-cache miss/writeback interfaces. A single command is latched per
// grant and held on the memory port until mem_ready; the returned line goes
// only to the granted requester. Per-requester saturating grant counters
// are kept for performance reporting.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no transaction; arbitrate pending requests, latch winner
// BUSY_I  | I-side command on the memory port, waiting for mem_ready
// BUSY_D  | D-side command on the memory port, waiting for mem_ready
// RELEASE | one dead cycle, requests low, so requester and memory see
//         | the deassert before the next grant
module mem_port_arbiter #(
  parameter int ADDR_W    = 28,
  parameter int DATA_W    = 128,
  parameter int PRIO_MODE = 0,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  i_grant_cnt,
  output logic [CNT_W-1:0]  d_grant_cnt
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY_I  = 2'd1;
  localparam logic [1:0] BUSY_D  = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              last_d;      // 1 when D held the most recent grant
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_rd;
  logic              lat_wr;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic [CNT_W-1:0]  i_cnt;
  logic [CNT_W-1:0]  d_cnt;
  logic              i_pend;
  logic              d_pend;
  logic              grant_i;
  logic              grant_d;
  logic              busy;
  logic              done_i;
  logic              done_d;

  assign i_pend = i_read | i_write;
  assign d_pend = d_read | d_write;
  assign busy   = (state == BUSY_I) || (state == BUSY_D);
  assign done_i = (state == BUSY_I) && mem_ready;
  assign done_d = (state == BUSY_D) && mem_ready;

  // Arbitration: only evaluated in IDLE; ties go to the side that did not
  // win last time, or always to D in fixed-priority mode.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE) begin
      if (i_pend && d_pend) begin
        if (PRIO_MODE != 0) begin
          grant_d = 1'b1;
        end else if (last_d) begin
          grant_i = 1'b1;
        end else begin
          grant_d = 1'b1;
        end
      end else if (i_pend) begin
        grant_i = 1'b1;
      end else if (d_pend) begin
        grant_d = 1'b1;
      end
    end
  end

  // Next-state logic; mem_ready outside BUSY_x is ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_i) begin
          state_nxt = BUSY_I;
        end else if (grant_d) begin
          state_nxt = BUSY_D;
        end
      end
      BUSY_I: begin
        if (mem_ready) begin
          state_nxt = RELEASE;
        end
      end
      BUSY_D: begin
        if (mem_ready) begin
          state_nxt = RELEASE;
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Command latch on grant. Write wins when read and write are both raised.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_rd    <= 1'b0;
      lat_wr    <= 1'b0;
      last_d    <= 1'b1;
    end else if (grant_i) begin
      lat_addr  <= i_addr;
      lat_wdata <= i_wdata;
      lat_rd    <= i_read & ~i_write;
      lat_wr    <= i_write;
      last_d    <= 1'b0;
    end else if (grant_d) begin
      lat_addr  <= d_addr;
      lat_wdata <= d_wdata;
      lat_rd    <= d_read & ~d_write;
      lat_wr    <= d_write;
      last_d    <= 1'b1;
    end
  end

  // Returned line is held per requester until its next completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (done_i) begin
        i_rdata_q <= mem_rdata;
      end
      if (done_d) begin
        d_rdata_q <= mem_rdata;
      end
    end
  end

  // Saturating completion counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_cnt <= '0;
      d_cnt <= '0;
    end else begin
      if (done_i && (i_cnt != CNT_MAX)) begin
        i_cnt <= i_cnt + CNT_ONE;
      end
      if (done_d && (d_cnt != CNT_MAX)) begin
        d_cnt <= d_cnt + CNT_ONE;
      end
    end
  end

  assign mem_read    = busy & lat_rd;
  assign mem_write   = busy & lat_wr;
  assign mem_addr    = lat_addr;
  assign mem_wdata   = lat_wdata;

  // Completion data is forwarded in the ready cycle itself.
  assign i_ready     = done_i;
  assign d_ready     = done_d;
  assign i_rdata     = done_i ? mem_rdata : i_rdata_q;
  assign d_rdata     = done_d ? mem_rdata : d_rdata_q;

  assign i_grant_cnt = i_cnt;
  assign d_grant_cnt = d_cnt;

endmodule
